range_sample_framer: RTL and testbench
======================================

Name: range_sample_framer

Overview:
- Upstream feeder for the range-finder stage.
- Buffers incoming samples from a valid/ready stream in a small FIFO, then emits fixed-length frames on the range finder's go/data/finish protocol.
- Each frame is contiguous: one sample per cycle, go with the first sample, finish with the last.
- A frame never starts until the whole frame is already buffered, so the downstream stage never sees a gap.

Parameters:
- WIDTH, 10, sample width; matches the range finder data width.
- DEPTH, 16, FIFO depth in samples; power of two, at least 2.
- LEN_W, $clog2(DEPTH)+1, localparam; width of frame_len and the occupancy count.

Ports:
- clock  input  1  system clock; all state is updated on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  sample from the upstream source.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a sample this cycle.
- frame_len  input  LEN_W  samples per frame; legal range is 2..DEPTH.
- enable  input  1  permits new frames to start.
- data_out  output  WIDTH  sample to the range finder.
- go  output  1  one-cycle pulse, coincident with the first sample of a frame.
- finish  output  1  one-cycle pulse, coincident with the last sample of a frame.
- busy  output  1  a frame is in flight.
- cfg_error  output  1  sticky flag: an illegal frame_len was seen while idle.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - While reset_n=0, everything clears immediately, without waiting for a clock edge: FIFO empty, count=0, state=IDLE, data_out=0, go=0, finish=0, busy=0, cfg_error=0.
  - Reset asserted mid-frame abandons the frame. go/finish drop at once, and buffered samples are discarded.
- FIFO:
  - Circular buffer with read and write pointers plus count (LEN_W bits).
  - in_ready = (count != DEPTH). in_ready is combinational from registered count only.
  - A push happens when in_valid && in_ready.
  - Push and pop in the same cycle is legal; count stays unchanged.
  - When full, the sample is refused (in_ready=0); upstream must hold it.
  - Pointers wrap modulo DEPTH.
- State machine (IDLE, STREAM, GAP):
  - IDLE to STREAM:
    - Condition: enable=1, frame_len legal, and count >= frame_len.
    - frame_len is captured into len_q.
    - The head is popped into data_out, go=1, busy=1, and remaining = len_q-1.
  - STREAM, every cycle:
    - Pop the head into data_out and decrement remaining.
    - When remaining==1 before the decrement, finish=1 on this pop, then go to GAP.
  - GAP:
    - One cycle with go=0, finish=0, busy=0, then back to IDLE.
    - This guarantees at least one idle cycle between finish and the next go.
  - frame_len and enable are ignored outside IDLE. Deasserting enable mid-frame does not truncate the frame.
- cfg_error: set in IDLE when frame_len<2 or frame_len>DEPTH. No frame starts while it is illegal. The flag is cleared only by reset.
- Output timing:
  - All outputs except in_ready are registered.
  - data_out holds its last value outside frames.
  - go and finish are never high together (minimum length is 2).
- Latency: go rises on the clock edge after the cycle in which count reaches frame_len, if the FSM is idle and enabled.
- Throughput: a frame of N samples occupies N+1 cycles (N data cycles plus 1 gap).

Optional Feature:
- Macro: FRAMER_DROP_CNT_EN.
- When defined:
  - Adds output drop_count, 8 bits.
  - It counts cycles with in_valid && !in_ready, saturates at 255, and resets to 0.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package framer_pkg:
  - Enum framer_state_t {IDLE, STREAM, GAP}.
  - Constant FRAMER_MIN_LEN = 2.
- One natural sub-module: sample_fifo, parameterised by WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata (head, show-ahead), count, full, empty.
  - The FSM lives in range_sample_framer.

Test Plan:
- Single frame: frame_len=4, enable=1, push 5,9,2,7 back-to-back.
  - go rises the edge after the 4th push, with data_out=5.
  - Following cycles give 9, 2, then 7 with finish=1.
  - busy is high for exactly 4 cycles.
- Back-to-back frames: frame_len=3, push 6 samples continuously.
  - Two frames are emitted with exactly one go=0/finish=0 cycle between finish and the second go.
  - Data order is preserved.
- Full FIFO: enable=0, push 17 samples with DEPTH=16.
  - in_ready=0 after 16 samples; the 17th is held off.
  - With FRAMER_DROP_CNT_EN, drop_count=1 after one stalled cycle.
  - Then enable=1, frame_len=16: all 16 are streamed in order.
- Illegal length: frame_len=1 with 4 samples buffered.
  - cfg_error=1, no go.
  - frame_len=17: no go.
  - Reset clears the flag.
- Mid-frame events: frame_len=8, drop enable after go.
  - The frame still completes with finish on the 8th sample.
  - In a second run, pulse reset_n=0 at sample 4: go/finish/busy=0 immediately, and count=0 after release.
- Simultaneous push/pop: stream at one sample per cycle during a frame with frame_len=4 and 4 buffered.
  - count stays constant through the frame.
  - The next frame starts right after GAP.

Source files
------------

// File: rtl/framer_pkg.sv
// Shared types and constants for the range-finder sample framer.
package framer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } framer_state_t;

    // Shortest frame the range finder accepts; go and finish can never coincide.
    localparam int FRAMER_MIN_LEN = 2;

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead circular sample buffer with occupancy count; rdata is always the head.
module sample_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LEN_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LEN_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + LEN_W'(1);
                2'b01:   count_q <= count_q - LEN_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; clearing the pointers/count already makes it logically empty.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == LEN_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/range_sample_framer.sv
// Buffers a valid/ready sample stream and emits gap-free go/data/finish frames.
// Optional FRAMER_DROP_CNT_EN adds a saturating count of refused-push cycles.
module range_sample_framer
    import framer_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             enable,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic             busy,
`ifdef FRAMER_DROP_CNT_EN
    output logic [7:0]       drop_count,
`endif
    output logic             cfg_error
);

    framer_state_t    state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             go_q, go_d;
    logic             fin_q, fin_d;
    logic             busy_q, busy_d;
    logic             cfg_err_q, cfg_err_d;

    logic             push, pop, pop_req;
    logic [WIDTH-1:0] fifo_rdata;
    logic [LEN_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             len_legal;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign pop       = pop_req && !fifo_empty;
    assign len_legal = (frame_len >= LEN_W'(FRAMER_MIN_LEN)) && (frame_len <= LEN_W'(DEPTH));

    sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (in_data),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        data_d    = data_q;
        go_d      = 1'b0;
        fin_d     = 1'b0;
        busy_d    = 1'b0;
        cfg_err_d = cfg_err_q;
        pop_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!len_legal) begin
                    cfg_err_d = 1'b1;
                end else if (enable && (fifo_count >= frame_len)) begin
                    pop_req = 1'b1;
                    data_d  = fifo_rdata;
                    go_d    = 1'b1;
                    busy_d  = 1'b1;
                    rem_d   = frame_len - LEN_W'(1);
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // The whole frame was buffered at go, so the head is always valid here.
                pop_req = 1'b1;
                data_d  = fifo_rdata;
                busy_d  = 1'b1;
                rem_d   = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    fin_d   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            data_q    <= '0;
            go_q      <= 1'b0;
            fin_q     <= 1'b0;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            go_q      <= go_d;
            fin_q     <= fin_d;
            busy_q    <= busy_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign data_out  = data_q;
    assign go        = go_q;
    assign finish    = fin_q;
    assign busy      = busy_q;
    assign cfg_error = cfg_err_q;

`ifdef FRAMER_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else if (in_valid && !in_ready && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_range_sample_framer.sv
// Directed self-checking bench for range_sample_framer (WIDTH=10, DEPTH=16).
module tb_range_sample_framer;

    localparam int WIDTH = 10;
    localparam int DEPTH = 16;
    localparam int LEN_W = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [LEN_W-1:0] frame_len = LEN_W'(4);
    logic             enable = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             go, finish, busy, cfg_error;
`ifdef FRAMER_DROP_CNT_EN
    logic [7:0]       drop_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    range_sample_framer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .frame_len (frame_len),
        .enable    (enable),
        .data_out  (data_out),
        .go        (go),
        .finish    (finish),
        .busy      (busy),
`ifdef FRAMER_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .cfg_error (cfg_error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of run, expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic g, input logic f, input logic b,
                           input logic [WIDTH-1:0] d);
        chk({tag, ".go"}, 32'(go), 32'(g));
        chk({tag, ".finish"}, 32'(finish), 32'(f));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".data"}, 32'(data_out), 32'(d));
    endtask

    // Advance one rising edge and settle so registered outputs can be sampled.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state.
        #1 reset_n = 1'b0;
        #2;
        chk_out("reset", 1'b0, 1'b0, 1'b0, '0);
        chk("reset.cfg_error", 32'(cfg_error), 0);
        chk("reset.in_ready", 32'(in_ready), 1);
`ifdef FRAMER_DROP_CNT_EN
        chk("reset.drop_count", 32'(drop_count), 0);
`endif
        #19 reset_n = 1'b1;

        // Single frame of 4: 5, 9, 2, 7.
        frame_len = LEN_W'(4);
        enable    = 1'b1;
        in_valid  = 1'b1;
        in_data = WIDTH'(5); tick(); chk("single.p1.go", 32'(go), 0);
        in_data = WIDTH'(9); tick(); chk("single.p2.go", 32'(go), 0);
        in_data = WIDTH'(2); tick(); chk("single.p3.go", 32'(go), 0);
        in_data = WIDTH'(7); tick(); chk("single.p4.go", 32'(go), 0);
        in_valid = 1'b0;
        tick(); chk_out("single.s1", 1'b1, 1'b0, 1'b1, WIDTH'(5));
        tick(); chk_out("single.s2", 1'b0, 1'b0, 1'b1, WIDTH'(9));
        tick(); chk_out("single.s3", 1'b0, 1'b0, 1'b1, WIDTH'(2));
        tick(); chk_out("single.s4", 1'b0, 1'b1, 1'b1, WIDTH'(7));
        tick(); chk_out("single.gap", 1'b0, 1'b0, 1'b0, WIDTH'(7));

        // Back-to-back frames of 3 from a continuous 6-sample burst 11..16.
        frame_len = LEN_W'(3);
        in_valid  = 1'b1;
        in_data = WIDTH'(11); tick();
        in_data = WIDTH'(12); tick();
        in_data = WIDTH'(13); tick(); chk("b2b.p3.go", 32'(go), 0);
        in_data = WIDTH'(14); tick(); chk_out("b2b.f1s1", 1'b1, 1'b0, 1'b1, WIDTH'(11));
        in_data = WIDTH'(15); tick(); chk_out("b2b.f1s2", 1'b0, 1'b0, 1'b1, WIDTH'(12));
        in_data = WIDTH'(16); tick(); chk_out("b2b.f1s3", 1'b0, 1'b1, 1'b1, WIDTH'(13));
        in_valid = 1'b0;
        tick(); chk_out("b2b.gap", 1'b0, 1'b0, 1'b0, WIDTH'(13));
        tick(); chk_out("b2b.f2s1", 1'b1, 1'b0, 1'b1, WIDTH'(14));
        tick(); chk_out("b2b.f2s2", 1'b0, 1'b0, 1'b1, WIDTH'(15));
        tick(); chk_out("b2b.f2s3", 1'b0, 1'b1, 1'b1, WIDTH'(16));
        tick(); chk_out("b2b.gap2", 1'b0, 1'b0, 1'b0, WIDTH'(16));

        // Full FIFO: 16 accepted, the 17th held off, then one 16-sample frame.
        enable   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("full.ready_before_push", 32'(in_ready), 1);
            in_data = WIDTH'(100 + i);
            tick();
            chk("full.go_while_disabled", 32'(go), 0);
        end
        chk("full.ready_at_16", 32'(in_ready), 0);
        in_data = WIDTH'(116);
        tick();
        chk("full.ready_stalled", 32'(in_ready), 0);
`ifdef FRAMER_DROP_CNT_EN
        chk("full.drop_count", 32'(drop_count), 1);
`endif
        in_valid  = 1'b0;
        enable    = 1'b1;
        frame_len = LEN_W'(16);
        tick();
        chk_out("full.s0", 1'b1, 1'b0, 1'b1, WIDTH'(100));
        chk("full.ready_after_pop", 32'(in_ready), 1);
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            chk_out($sformatf("full.s%0d", i), 1'b0, (i == DEPTH - 1), 1'b1, WIDTH'(100 + i));
        end
        tick(); chk_out("full.gap", 1'b0, 1'b0, 1'b0, WIDTH'(115));

        // Illegal lengths with 4 samples buffered.
        frame_len = LEN_W'(1);
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = WIDTH'(21 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("illegal1.cfg_error", 32'(cfg_error), 1);
        tick(); chk("illegal1.go", 32'(go), 0);
        tick(); chk("illegal1.busy", 32'(busy), 0);
        frame_len = LEN_W'(17);
        tick(); chk("illegal17.go_a", 32'(go), 0);
        tick(); chk("illegal17.go_b", 32'(go), 0);
        chk("illegal17.cfg_error", 32'(cfg_error), 1);
        reset_n = 1'b0;
        #1;
        chk("illegal.reset_clears_flag", 32'(cfg_error), 0);
        #1 reset_n = 1'b1;

        // Mid-frame enable drop: frame of 8 still completes.
        frame_len = LEN_W'(8);
        enable    = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = WIDTH'(30 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_en.p8.go", 32'(go), 0);
        tick(); chk_out("mid_en.s0", 1'b1, 1'b0, 1'b1, WIDTH'(30));
        enable = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_out($sformatf("mid_en.s%0d", i), 1'b0, (i == 7), 1'b1, WIDTH'(30 + i));
        end
        tick(); chk_out("mid_en.gap", 1'b0, 1'b0, 1'b0, WIDTH'(37));

        // Mid-frame reset at the 4th sample abandons frame and buffer.
        enable   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = WIDTH'(40 + i);
            tick();
        end
        in_valid = 1'b0;
        tick(); chk_out("mid_rst.s0", 1'b1, 1'b0, 1'b1, WIDTH'(40));
        tick(); tick(); tick();
        chk_out("mid_rst.s3", 1'b0, 1'b0, 1'b1, WIDTH'(43));
        reset_n = 1'b0;
        #1;
        chk_out("mid_rst.async", 1'b0, 1'b0, 1'b0, '0);
        frame_len = LEN_W'(2);
        #1 reset_n = 1'b1;
        in_valid = 1'b1;
        in_data = WIDTH'(50); tick(); chk("mid_rst.empty_a.go", 32'(go), 0);
        in_data = WIDTH'(51); tick(); chk("mid_rst.empty_b.go", 32'(go), 0);
        in_valid = 1'b0;
        tick(); chk_out("mid_rst.new_s0", 1'b1, 1'b0, 1'b1, WIDTH'(50));
        tick(); chk_out("mid_rst.new_s1", 1'b0, 1'b1, 1'b1, WIDTH'(51));
        tick(); chk_out("mid_rst.gap", 1'b0, 1'b0, 1'b0, WIDTH'(51));

        // Simultaneous push/pop: second frame is fed while the first streams.
        frame_len = LEN_W'(4);
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = WIDTH'(60 + i);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            in_data = WIDTH'(64 + i);
            tick();
            chk_out($sformatf("pp.f1s%0d", i), (i == 0), (i == 3), 1'b1, WIDTH'(60 + i));
            chk("pp.ready", 32'(in_ready), 1);
        end
        in_valid = 1'b0;
        tick(); chk_out("pp.gap", 1'b0, 1'b0, 1'b0, WIDTH'(63));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("pp.f2s%0d", i), (i == 0), (i == 3), 1'b1, WIDTH'(64 + i));
        end
        tick(); chk_out("pp.gap2", 1'b0, 1'b0, 1'b0, WIDTH'(67));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
